xdisp_feed: RTL and testbench
=============================

Name: xdisp_feed

Overview:
- Upstream feeder for the 7-segment display driver.
- Accepts signed values written by the CPU-side bus and saturates them to the displayable range of -999..999.
- Presents each value as an 11-bit two's-complement word plus a one-cycle select strobe to the display driver (its data_in/sel inputs).
- Rate-limits updates with a minimum hold period so the display does not flicker; only the latest pending write is kept.

Parameters:
- IN_W, 16: width of the signed bus write data.
- HOLD_CYCLES, 4: minimum number of clk cycles a forwarded value is held before the next one may be forwarded. Must be >=1; the silicon build uses 5000000.

Ports:
- clk  input  1  system clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- sel  input  1  bus module select.
- we  input  1  bus write enable; a write is accepted when sel && we.
- wdata  input  IN_W  signed two's-complement value to display.
- data_out  output  11  signed value to the display driver (bit 10 = sign).
- disp_sel  output  1  one-cycle strobe to the display driver's sel input.
- busy  output  1  high while in HOLD.
- ovf  output  1  high if the currently forwarded value was clamped.
- drop_cnt  output  8  count of overwritten pending writes (see Optional Feature).

Behaviour:
- Reset (rst=1 at a clk edge): data_out=0, disp_sel=0, busy=0, ovf=0, drop_cnt=0, pend_valid=0, state=IDLE, hold counter=0. Reset mid-HOLD discards the pending value.
- Write capture: on any edge with sel&&we, wdata is loaded into the pending register and pend_valid is set. Writes are always accepted; there is no backpressure.
- Latest write wins: a write while pend_valid=1 and the pending value is not consumed that edge overwrites it (a drop).
- Clamp, combinational on the pending value:
  - v > 999 -> 999 (11'h3E7), ovf=1.
  - v < -999 -> -999 (11'h419), ovf=1.
  - Otherwise v[10:0], ovf=0.
  - Comparison is full IN_W signed arithmetic.
- FSM, two states (IDLE, HOLD):
  - IDLE && pend_valid at an edge: register clamped value into data_out and ovf, disp_sel<=1, hold counter<=HOLD_CYCLES-1, state<=HOLD, pend_valid cleared.
  - HOLD: disp_sel<=0 every edge. If the counter is 0, state<=IDLE; else decrement.
  - busy = (state==HOLD).
- Latency: write at edge E0 while IDLE -> data_out valid and disp_sel=1 after edge E1. disp_sel drops after E1+1.
- Update spacing: the next forward occurs no earlier than edge E1+HOLD_CYCLES+1.
- Simultaneous write and consume: if a write arrives at the edge where IDLE consumes pend_valid, the old pending value is forwarded. The new write becomes pending (pend_valid stays 1); it is not counted as a drop.
- Simultaneous rst and write: rst wins.
- data_out and ovf hold their values between forwards.

Optional Feature:
- Macro XDISP_FEED_DROPCNT_EN.
- Defined: drop_cnt increments on every overwrite of an unconsumed pending value. It saturates at 8'hFF and is cleared only by rst.
- Undefined: no counter logic; drop_cnt is tied to 8'h00.

Test Plan:
- Reset then write wdata=16'd123 -> one edge later data_out=11'h07B, disp_sel pulses for 1 cycle, ovf=0, busy=1 for exactly 4 cycles.
- Write wdata=-16'd45 -> data_out=11'h7D3, ovf=0. The display shows "-45".
- Write 16'd1500 -> data_out=11'h3E7, ovf=1. Then write -16'd2000 after HOLD -> data_out=11'h419, ovf=1.
- During HOLD, write 10, 20, 30 on consecutive cycles -> after HOLD ends, one forward with data_out=30. drop_cnt=2 with the macro, 0 without.
- Write exactly on the edge IDLE consumes a pending 7 (new value 8) -> 7 forwarded, 8 forwarded after HOLD. drop_cnt unchanged.
- Assert rst mid-HOLD with a pending value -> all outputs 0 next cycle, no forward afterwards.

Source files
------------

// File: rtl/xdisp_feed.sv
// Rate-limited, saturating feeder for the 7-segment display driver.
// Optional overwrite counter enabled by defining XDISP_FEED_DROPCNT_EN.
module xdisp_feed #(
    parameter int IN_W        = 16,
    parameter int HOLD_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sel,
    input  logic            we,
    input  logic [IN_W-1:0] wdata,
    output logic [10:0]     data_out,
    output logic            disp_sel,
    output logic            busy,
    output logic            ovf,
    output logic [7:0]      drop_cnt
);

    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0]       HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic signed [IN_W-1:0] POS_LIM   = IN_W'(999);
    localparam logic signed [IN_W-1:0] NEG_LIM   = IN_W'(-999);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IN_W-1:0]  pend_q, pend_d;
    logic             pend_valid_q, pend_valid_d;
    logic [10:0]      data_q, data_d;
    logic             ovf_q, ovf_d;
    logic             disp_sel_q, disp_sel_d;
    logic             wr;
    logic             consume;
    logic [10:0]      clamp_val;
    logic             clamp_ovf;

    assign wr      = sel & we;
    assign consume = (state_q == IDLE) & pend_valid_q;

    always_comb begin
        clamp_val = pend_q[10:0];
        clamp_ovf = 1'b0;
        if ($signed(pend_q) > POS_LIM) begin
            clamp_val = 11'h3E7;
            clamp_ovf = 1'b1;
        end else if ($signed(pend_q) < NEG_LIM) begin
            clamp_val = 11'h419;
            clamp_ovf = 1'b1;
        end
    end

    // A write on the consume edge becomes the new pending value.
    assign pend_d       = wr ? wdata : pend_q;
    assign pend_valid_d = wr | (pend_valid_q & ~consume);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        ovf_d      = ovf_q;
        disp_sel_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pend_valid_q) begin
                    data_d     = clamp_val;
                    ovf_d      = clamp_ovf;
                    disp_sel_d = 1'b1;
                    cnt_d      = HOLD_LOAD;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            data_q       <= '0;
            ovf_q        <= 1'b0;
            disp_sel_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            data_q       <= data_d;
            ovf_q        <= ovf_d;
            disp_sel_q   <= disp_sel_d;
        end
    end

    assign data_out = data_q;
    assign ovf      = ovf_q;
    assign disp_sel = disp_sel_q;
    assign busy     = (state_q == HOLD);

`ifdef XDISP_FEED_DROPCNT_EN
    logic [7:0] drop_q;
    logic       drop;

    assign drop = wr & pend_valid_q & ~consume;

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q <= 8'h00;
        end else if (drop && (drop_q != 8'hFF)) begin
            drop_q <= drop_q + 8'h01;
        end
    end

    assign drop_cnt = drop_q;
`else
    assign drop_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_xdisp_feed.sv
// Self-checking bench for xdisp_feed: directed scenarios plus randomized traffic
// compared against an edge-indexed timeline model.
module tb_xdisp_feed;

    localparam int IN_W = 16;
    localparam int H    = 4;

    logic            clk;
    logic            rst;
    logic            sel;
    logic            we;
    logic [IN_W-1:0] wdata;
    logic [10:0]     data_out;
    logic            disp_sel;
    logic            busy;
    logic            ovf;
    logic [7:0]      drop_cnt;

    int checks = 0;
    int errors = 0;

    xdisp_feed #(.IN_W(IN_W), .HOLD_CYCLES(H)) dut (
        .clk      (clk),
        .rst      (rst),
        .sel      (sel),
        .we       (we),
        .wdata    (wdata),
        .data_out (data_out),
        .disp_sel (disp_sel),
        .busy     (busy),
        .ovf      (ovf),
        .drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: edge index t, edge of the last forward, pending slot.
    int              t      = 0;
    int              last_f = -100;
    bit              m_pv   = 0;
    logic [IN_W-1:0] m_pval = '0;
    logic [10:0]     m_data = '0;
    bit              m_ovf  = 0;
    int              m_drop = 0;

    function automatic int exp_drop();
`ifdef XDISP_FEED_DROPCNT_EN
        return m_drop;
`else
        return 0;
`endif
    endfunction

    function automatic bit exp_sel();
        return (last_f == t);
    endfunction

    function automatic bit exp_busy();
        return (t >= last_f) && (t <= last_f + H - 1);
    endfunction

    task automatic model_edge(input bit r, input bit wr, input logic [IN_W-1:0] d);
        int  v;
        bit  cons;
        t = t + 1;
        if (r) begin
            m_pv = 0; m_data = '0; m_ovf = 0; m_drop = 0; last_f = -100;
        end else begin
            cons = m_pv && (t >= last_f + H + 1);
            if (cons) begin
                v = int'($signed(m_pval));
                if (v > 999) begin
                    m_data = 11'h3E7; m_ovf = 1;
                end else if (v < -999) begin
                    m_data = 11'h419; m_ovf = 1;
                end else begin
                    m_data = m_pval[10:0]; m_ovf = 0;
                end
                last_f = t;
            end
            if (wr) begin
                if (m_pv && !cons && m_drop < 255) m_drop = m_drop + 1;
                m_pv   = 1;
                m_pval = d;
            end else if (cons) begin
                m_pv = 0;
            end
        end
    endtask

    task automatic tick(input bit r, input bit s, input bit w, input logic [IN_W-1:0] d);
        rst = r; sel = s; we = w; wdata = d;
        if (s && w) $display("write t=%0d rst=%0b wdata=%0d", t + 1, r, $signed(d));
        model_edge(r, s && w, d);
        @(posedge clk);
        #1;
        rst = 1'b0; sel = 1'b0; we = 1'b0;
    endtask

    task automatic test_reset();
        tick(1, 0, 0, '0);
        checks++;
        if ({data_out, disp_sel, busy, ovf, drop_cnt} !== 22'h0) begin
            errors++;
            $display("FAIL reset_outputs got data=%h sel=%b busy=%b ovf=%b drop=%0d required all zero",
                     data_out, disp_sel, busy, ovf, drop_cnt);
        end
        tick(1, 1, 1, 16'd55);
        tick(0, 0, 0, '0);
        checks++;
        if (disp_sel !== 1'b0 || data_out !== 11'h000) begin
            errors++;
            $display("FAIL reset_wins_write got sel=%b data=%h required sel=0 data=000", disp_sel, data_out);
        end
    endtask

    task automatic test_basic();
        tick(0, 1, 1, 16'd123);
        checks++;
        if (disp_sel !== 1'b0) begin
            errors++;
            $display("FAIL basic_latency got sel=%b required 0", disp_sel);
        end
        tick(0, 0, 0, '0);
        checks++;
        if (data_out !== 11'h07B || disp_sel !== 1'b1 || ovf !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_forward got data=%h sel=%b ovf=%b busy=%b required 07b 1 0 1",
                     data_out, disp_sel, ovf, busy);
        end
        for (int i = 0; i < H - 1; i++) begin
            tick(0, 0, 0, '0);
            checks++;
            if (busy !== 1'b1 || disp_sel !== 1'b0) begin
                errors++;
                $display("FAIL basic_hold%0d got busy=%b sel=%b required 1 0", i, busy, disp_sel);
            end
        end
        tick(0, 0, 0, '0);
        checks++;
        if (busy !== 1'b0 || data_out !== 11'h07B) begin
            errors++;
            $display("FAIL basic_hold_end got busy=%b data=%h required 0 07b", busy, data_out);
        end
    endtask

    task automatic test_negative();
        tick(0, 1, 1, 16'hFFD3);
        tick(0, 0, 0, '0);
        checks++;
        if (data_out !== 11'h7D3 || ovf !== 1'b0 || disp_sel !== 1'b1) begin
            errors++;
            $display("FAIL negative got data=%h ovf=%b sel=%b required 7d3 0 1", data_out, ovf, disp_sel);
        end
        repeat (H) tick(0, 0, 0, '0);
    endtask

    task automatic test_clamp();
        tick(0, 1, 1, 16'd1500);
        tick(0, 0, 0, '0);
        checks++;
        if (data_out !== 11'h3E7 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL clamp_pos got data=%h ovf=%b required 3e7 1", data_out, ovf);
        end
        repeat (H) tick(0, 0, 0, '0);
        checks++;
        if (ovf !== 1'b1 || data_out !== 11'h3E7) begin
            errors++;
            $display("FAIL clamp_hold got data=%h ovf=%b required 3e7 1", data_out, ovf);
        end
        tick(0, 1, 1, 16'hF830);
        tick(0, 0, 0, '0);
        checks++;
        if (data_out !== 11'h419 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL clamp_neg got data=%h ovf=%b required 419 1", data_out, ovf);
        end
        repeat (H) tick(0, 0, 0, '0);
    endtask

    task automatic test_overwrite();
        int d0;
        d0 = exp_drop();
        tick(0, 1, 1, 16'd5);
        tick(0, 0, 0, '0);
        tick(0, 1, 1, 16'd10);
        tick(0, 1, 1, 16'd20);
        tick(0, 1, 1, 16'd30);
        tick(0, 0, 0, '0);
        checks++;
        if (data_out !== 11'h005 || disp_sel !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL overwrite_wait got data=%h sel=%b busy=%b required 005 0 0", data_out, disp_sel, busy);
        end
        tick(0, 0, 0, '0);
        checks++;
        if (data_out !== 11'h01E || disp_sel !== 1'b1) begin
            errors++;
            $display("FAIL overwrite_latest got data=%h sel=%b required 01e 1", data_out, disp_sel);
        end
        checks++;
`ifdef XDISP_FEED_DROPCNT_EN
        if (int'(drop_cnt) !== d0 + 2) begin
            errors++;
            $display("FAIL overwrite_drops got %0d required %0d", drop_cnt, d0 + 2);
        end
`else
        if (drop_cnt !== 8'h00) begin
            errors++;
            $display("FAIL overwrite_drops got %0d required 0", drop_cnt);
        end
`endif
        repeat (H) tick(0, 0, 0, '0);
    endtask

    task automatic test_simul_consume();
        int d0;
        d0 = exp_drop();
        tick(0, 1, 1, 16'd7);
        tick(0, 1, 1, 16'd8);
        checks++;
        if (data_out !== 11'h007 || disp_sel !== 1'b1) begin
            errors++;
            $display("FAIL simul_old got data=%h sel=%b required 007 1", data_out, disp_sel);
        end
        for (int i = 0; i < H; i++) begin
            tick(0, 0, 0, '0);
            checks++;
            if (disp_sel !== 1'b0 || data_out !== 11'h007) begin
                errors++;
                $display("FAIL simul_hold%0d got data=%h sel=%b required 007 0", i, data_out, disp_sel);
            end
        end
        tick(0, 0, 0, '0);
        checks++;
        if (data_out !== 11'h008 || disp_sel !== 1'b1 || int'(drop_cnt) !== d0) begin
            errors++;
            $display("FAIL simul_new got data=%h sel=%b drop=%0d required 008 1 %0d",
                     data_out, disp_sel, drop_cnt, d0);
        end
        repeat (H) tick(0, 0, 0, '0);
    endtask

    task automatic test_reset_mid_hold();
        tick(0, 1, 1, 16'd100);
        tick(0, 0, 0, '0);
        tick(0, 1, 1, 16'd200);
        tick(1, 0, 0, '0);
        checks++;
        if ({data_out, disp_sel, busy, ovf, drop_cnt} !== 22'h0) begin
            errors++;
            $display("FAIL midhold_reset got data=%h sel=%b busy=%b ovf=%b drop=%0d required all zero",
                     data_out, disp_sel, busy, ovf, drop_cnt);
        end
        for (int i = 0; i < 2 * H; i++) begin
            tick(0, 0, 0, '0);
            checks++;
            if (disp_sel !== 1'b0 || data_out !== 11'h000 || busy !== 1'b0) begin
                errors++;
                $display("FAIL midhold_quiet%0d got data=%h sel=%b busy=%b required 000 0 0",
                         i, data_out, disp_sel, busy);
            end
        end
    endtask

    task automatic test_random();
        logic [IN_W-1:0] d;
        bit              r;
        bit              w;
        int              v;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0: d = IN_W'($urandom);
                1: begin v = int'($urandom_range(0, 1998)) - 999; d = IN_W'(v); end
                2: begin
                    v = int'($urandom_range(995, 1003));
                    if ($urandom_range(0, 1) == 1) v = -v;
                    d = IN_W'(v);
                end
                default: begin
                    case ($urandom_range(0, 3))
                        0: d = 16'h7FFF;
                        1: d = 16'h8000;
                        2: d = 16'd1000;
                        default: d = 16'hFC18;
                    endcase
                end
            endcase
            r = ($urandom_range(0, 99) == 0);
            w = ($urandom_range(0, 9) < 4);
            tick(r, w, w, d);
            checks++;
            if (data_out !== m_data || disp_sel !== exp_sel() || busy !== exp_busy() ||
                ovf !== m_ovf || int'(drop_cnt) !== exp_drop()) begin
                errors++;
                $display("FAIL random_t%0d got data=%h sel=%b busy=%b ovf=%b drop=%0d required %h %b %b %b %0d",
                         t, data_out, disp_sel, busy, ovf, drop_cnt,
                         m_data, exp_sel(), exp_busy(), m_ovf, exp_drop());
            end
        end
    endtask

    initial begin
        rst = 1'b1; sel = 1'b0; we = 1'b0; wdata = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_negative();
        test_clamp();
        test_overwrite();
        test_simul_consume();
        test_reset_mid_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
